lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL expose ports in this order: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-002 The block SHALL expose core request ports: req_valid  in  1  request present; req_ready  out  1  block can accept; req_we  in  1  1=store, 0=load; req_funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU); req_addr  in  32  byte address; req_wdata  in  32  store data, LSB-aligned.
REQ-003 The block SHALL expose core response ports: rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  32  extended load data; rsp_err  out  1  misaligned or illegal funct3.
REQ-004 The block SHALL expose memory-side ports matching dmem: RW  out  1  1=write; address  out  32  word-aligned byte address; wdata  out  32  write word; rdata  in  32  read word.
REQ-005 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-006 dmem is modelled as combinational read of address and write on posedge clk when RW=1; the block SHALL drive address[1:0]=00 always.
REQ-007 FSM states SHALL be IDLE, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-008 Acceptance SHALL occur on a posedge with req_valid=1 and req_ready=1; request fields SHALL be latched at acceptance.
REQ-009 Load accepted at cycle N: READ in N+1 (RW=0, rdata captured), RESP in N+2 with rsp_valid=1.
REQ-010 Word store accepted at N: WRITE in N+1 (RW=1, wdata=req_wdata), RESP in N+2.
REQ-011 Byte/halfword store accepted at N: READ in N+1 (capture old word), WRITE in N+2 (merged word, untouched bytes preserved), RESP in N+3.
REQ-012 Byte lane SHALL be addr[1:0]; halfword lane SHALL be addr[1]; little-endian.
REQ-013 Loads SHALL sign-extend for B/H and zero-extend for BU/HU; W SHALL pass through.
REQ-014 Misalignment (H/HU with addr[0]=1, W with addr[1:0]!=00) or an undefined funct3 (011, 110, 111, or 1xx with req_we=1) SHALL go IDLE->RESP directly: rsp_valid and rsp_err=1 at N+1, RW never asserted, rsp_rdata=0.
REQ-015 rsp_rdata SHALL be 0 for stores and SHALL hold its value only during the rsp_valid cycle (0 otherwise).
REQ-016 RESP SHALL always return to IDLE next cycle; back-to-back requests SHALL be accepted in the cycle after RESP.
REQ-017 RW SHALL be 1 only in WRITE; exactly one write cycle per legal store.

Reset
REQ-018 While rst=1, state SHALL be IDLE and req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0, RW=0, address=0, wdata=0.
REQ-019 Reset asserted mid-transaction SHALL abort it immediately with no write issued after the reset edge and no response.

Structure
REQ-020 A shared package lsu_pkg SHALL hold the funct3 width constants and the state encoding.
REQ-021 A combinational sub-module lsu_align SHALL implement load extraction/extension and store merge; lsu holds the FSM and registers.

Verification
REQ-022 Store W 0xABCDEF00 @0x0, then load W @0x0 -> RW high one cycle at N+1, load rsp_rdata=0xABCDEF00 two cycles after acceptance.
REQ-023 Preload 0x12345678 @0x8; store B 0xAA @0x9 -> memory word 0x1234AA78, rsp_valid at N+3; load B @0x9 -> 0xFFFFFFAA; LBU -> 0x000000AA.
REQ-024 Preload 0xFFFF8001 @0x4; load H @0x4 -> 0xFFFF8001; HU @0x6 -> 0x0000FFFF; store H 0x1234 @0x6 -> word 0x12348001.
REQ-025 Load W @0x2 and store H @0x1 -> rsp_err=1 at N+1, RW stays 0, memory unchanged.
REQ-026 Assert rst during WRITE cycle of a byte store -> no write at following edge, outputs at reset values, next request completes normally.
REQ-027 Hold req_valid=1 continuously with three loads -> req_ready pulses only in IDLE, each rsp_valid exactly one cycle, three responses in order.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state encoding and the request legality check for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Unsigned widths only exist for loads; everything else must be naturally aligned.
  function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lane[0];
      F3_W:    bad = (lane != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: little-endian load extraction/extension and read-modify-write store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = old_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? old_word[31:16] : old_word[15:0];

    load_data = old_word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = old_word;
    endcase

    // Bytes outside the addressed lane keep the value read back from memory.
    store_word = old_word;
    case (funct3)
      F3_B:    store_word[{lane, 3'b000} +: 8]     = store_data[7:0];
      F3_H:    store_word[{lane[1], 4'b0000} +: 16] = store_data[15:0];
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between a core and a combinational-read dmem; one request in flight, req_ready only in IDLE.
// Latency: loads and word stores respond 2 cycles after acceptance, sub-word stores 3, illegal requests 1.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        RW,
  output logic [31:0] address,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  state_t      state, state_nx;
  logic        we_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, word_q;
  logic        accept, capture, bad;
  logic [31:0] load_data, store_word;

  assign bad     = req_bad(req_we, req_funct3, req_addr[1:0]);
  assign address = {addr_q[31:2], 2'b00};

  lsu_align u_align (
    .funct3     (f3_q),
    .lane       (addr_q[1:0]),
    .old_word   (word_q),
    .store_data (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    RW        = 1'b0;
    wdata     = 32'h0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (bad)                               state_nx = RESP;
          else if (req_we && req_funct3 == F3_W) state_nx = WRITE;
          else                                   state_nx = READ;
        end
      end
      READ: begin
        capture  = 1'b1;
        state_nx = we_q ? WRITE : RESP;
      end
      WRITE: begin
        RW       = 1'b1;
        wdata    = store_word;
        state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!we_q && !err_q) rsp_rdata = load_data;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        err_q   <= bad;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (capture) word_q <= rdata;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: word-array dmem model, directed checks from the requirements plus random traffic vs a reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        RW;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int n_chk = 0;
  int n_fail = 0;
  int addr_viol = 0;
  int idle_rd_viol = 0;

  logic [31:0] dmem    [0:63];
  logic [31:0] ref_mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_val = 32'h0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nrw;
  } vec_t;

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .RW         (RW),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata)
  );

  assign rdata = dmem[address[7:2]];

  always @(posedge clk) begin
    if (RW)         dmem[address[7:2]] <= wdata;
    else if (pl_en) dmem[pl_idx] <= pl_val;
  end

  always @(negedge clk) begin
    if (address[1:0] !== 2'b00) addr_viol++;
    if (!rsp_valid && rsp_rdata !== 32'h0) idle_rd_viol++;
  end

  task automatic preload(input int idx, input logic [31:0] v);
    pl_en = 1'b1; pl_idx = idx[5:0]; pl_val = v; ref_mem[idx] = v;
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Reference behaviour computed from the RV32I width/sign rules on a word array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat, output int nrw);
    logic [31:0] w, mask;
    int sh, idx;
    idx = int'(a[7:2]);
    w = ref_mem[idx];
    sh = 8 * int'(a[1:0]);
    rd = 32'h0; er = 1'b0; lat = 2; nrw = 0;
    if (f3 == 3'b011 || f3 >= 3'b110 || (f3 >= 3'b100 && we)) er = 1'b1;
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) er = 1'b1;
    if (f3 == 3'b010 && a[1:0] != 2'b00) er = 1'b1;
    if (er) begin
      lat = 1;
      return;
    end
    if (we) begin
      nrw = 1;
      if (f3 == 3'b010) ref_mem[idx] = wd;
      else begin
        lat = 3;
        mask = (f3 == 3'b000) ? 32'hFF : 32'hFFFF;
        ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
      end
    end else if (f3 == 3'b010) begin
      rd = w;
    end else if (f3[0] == 1'b0) begin
      rd = (w >> sh) & 32'hFF;
      if (f3 == 3'b000 && rd[7]) rd = rd | 32'hFFFFFF00;
    end else begin
      rd = (w >> sh) & 32'hFFFF;
      if (f3 == 3'b001 && rd[15]) rd = rd | 32'hFFFF0000;
    end
  endtask

  // Issues one request from an idle negedge and observes 8 cycles after acceptance.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output int nrw, output int nvld);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rd = 32'h0; er = 1'b0; lat = 0; nrw = 0; nvld = 0;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (RW) nrw++;
      if (rsp_valid) begin
        nvld++;
        if (lat == 0) begin
          lat = k; rd = rsp_rdata; er = rsp_err;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_chk++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_chk++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_chk++; if (RW !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b want 0", RW); end
    n_chk++; if (address !== 32'h0) begin n_fail++; $display("FAIL reset_address: got %h want 0", address); end
    n_chk++; if (wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", wdata); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_directed();
    vec_t v [13];
    logic [31:0] rd;
    logic er;
    int lat, nrw, nvld;
    preload(2, 32'h12345678);
    preload(1, 32'hFFFF8001);
    v[0]  = '{1'b1, 3'b010, 32'h0, 32'hABCDEF00, 32'h0,        1'b0, 2, 1};
    v[1]  = '{1'b0, 3'b010, 32'h0, 32'h0,        32'hABCDEF00, 1'b0, 2, 0};
    v[2]  = '{1'b1, 3'b000, 32'h9, 32'h000000AA, 32'h0,        1'b0, 3, 1};
    v[3]  = '{1'b0, 3'b000, 32'h9, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0};
    v[4]  = '{1'b0, 3'b100, 32'h9, 32'h0,        32'h000000AA, 1'b0, 2, 0};
    v[5]  = '{1'b0, 3'b001, 32'h4, 32'h0,        32'hFFFF8001, 1'b0, 2, 0};
    v[6]  = '{1'b0, 3'b101, 32'h6, 32'h0,        32'h0000FFFF, 1'b0, 2, 0};
    v[7]  = '{1'b1, 3'b001, 32'h6, 32'h00001234, 32'h0,        1'b0, 3, 1};
    v[8]  = '{1'b0, 3'b010, 32'h2, 32'h0,        32'h0,        1'b1, 1, 0};
    v[9]  = '{1'b1, 3'b001, 32'h1, 32'h00005555, 32'h0,        1'b1, 1, 0};
    v[10] = '{1'b0, 3'b010, 32'h4, 32'h0,        32'h12348001, 1'b0, 2, 0};
    v[11] = '{1'b0, 3'b011, 32'h0, 32'h0,        32'h0,        1'b1, 1, 0};
    v[12] = '{1'b1, 3'b100, 32'h8, 32'h000000EE, 32'h0,        1'b1, 1, 0};
    for (int i = 0; i < 13; i++) begin
      do_req(v[i].we, v[i].f3, v[i].a, v[i].wd, rd, er, lat, nrw, nvld);
      n_chk++; if (rd !== v[i].rd) begin n_fail++; $display("FAIL dir%0d_rdata: got %h want %h", i, rd, v[i].rd); end
      n_chk++; if (er !== v[i].er) begin n_fail++; $display("FAIL dir%0d_err: got %b want %b", i, er, v[i].er); end
      n_chk++; if (lat != v[i].lat) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, v[i].lat); end
      n_chk++; if (nrw != v[i].nrw) begin n_fail++; $display("FAIL dir%0d_write_cycles: got %0d want %0d", i, nrw, v[i].nrw); end
      n_chk++; if (nvld != 1) begin n_fail++; $display("FAIL dir%0d_rsp_pulses: got %0d want 1", i, nvld); end
    end
    n_chk++; if (dmem[0] !== 32'hABCDEF00) begin n_fail++; $display("FAIL dir_mem0: got %h want abcdef00", dmem[0]); end
    n_chk++; if (dmem[1] !== 32'h12348001) begin n_fail++; $display("FAIL dir_mem4: got %h want 12348001", dmem[1]); end
    n_chk++; if (dmem[2] !== 32'h1234AA78) begin n_fail++; $display("FAIL dir_mem8: got %h want 1234aa78", dmem[2]); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, erd;
    logic [2:0] f3;
    logic we, er, eer;
    int lat, elat, nrw, enrw, nvld;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    for (int t = 0; t < 200; t++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      model(we, f3, a, wd, erd, eer, elat, enrw);
      do_req(we, f3, a, wd, rd, er, lat, nrw, nvld);
      n_chk++; if (rd !== erd) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h (we=%b f3=%b a=%h)", t, rd, erd, we, f3, a); end
      n_chk++; if (er !== eer) begin n_fail++; $display("FAIL rnd%0d_err: got %b want %b (we=%b f3=%b a=%h)", t, er, eer, we, f3, a); end
      n_chk++; if (lat != elat) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, lat, elat); end
      n_chk++; if (nrw != enrw) begin n_fail++; $display("FAIL rnd%0d_write_cycles: got %0d want %0d", t, nrw, enrw); end
      n_chk++; if (nvld != 1) begin n_fail++; $display("FAIL rnd%0d_rsp_pulses: got %0d want 1", t, nvld); end
    end
    for (int i = 0; i < 64; i++) begin
      n_chk++; if (dmem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL rnd_mem%0d: got %h want %h", i, dmem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, elat, nrw, enrw, nvld, seen;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h9; req_wdata = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (RW !== 1'b1) begin n_fail++; $display("FAIL midrst_write_phase: RW got %b want 1", RW); end
    rst = 1'b1;
    #1;
    n_chk++; if (RW !== 1'b0) begin n_fail++; $display("FAIL midrst_rw: got %b want 0", RW); end
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
    n_chk++; if (address !== 32'h0) begin n_fail++; $display("FAIL midrst_address: got %h want 0", address); end
    n_chk++; if (wdata !== 32'h0) begin n_fail++; $display("FAIL midrst_wdata: got %h want 0", wdata); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL midrst_no_rsp: got %0d responses want 0", seen); end
    n_chk++; if (dmem[2] !== ref_mem[2]) begin n_fail++; $display("FAIL midrst_mem: got %h want %h", dmem[2], ref_mem[2]); end
    model(1'b0, 3'b000, 32'h9, 32'h0, erd, eer, elat, enrw);
    do_req(1'b0, 3'b000, 32'h9, 32'h0, rd, er, lat, nrw, nvld);
    n_chk++; if (rd !== erd) begin n_fail++; $display("FAIL midrst_next_rdata: got %h want %h", rd, erd); end
    n_chk++; if (lat != elat) begin n_fail++; $display("FAIL midrst_next_latency: got %0d want %0d", lat, elat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr [3];
    logic [2:0]  f3 [3];
    logic [31:0] erd [3];
    logic eer;
    int elat, enrw, got, issued, prev_vld, rdy_win;
    int acc [3];
    addr[0] = 32'h10; f3[0] = 3'b010;
    addr[1] = 32'h22; f3[1] = 3'b001;
    addr[2] = 32'h33; f3[2] = 3'b100;
    for (int i = 0; i < 3; i++) begin
      model(1'b0, f3[i], addr[i], 32'h0, erd[i], eer, elat, enrw);
      acc[i] = -1;
    end
    got = 0; issued = 0; prev_vld = 0; rdy_win = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (rsp_valid) begin
        n_chk++;
        if (got >= 3) begin
          n_fail++; $display("FAIL b2b_extra_rsp: cycle %0d got %0d responses want 3", cyc, got + 1);
        end else if (rsp_rdata !== erd[got] || cyc != 3 * got + 2) begin
          n_fail++; $display("FAIL b2b_rsp%0d: got %h at cycle %0d want %h at cycle %0d", got, rsp_rdata, cyc, erd[got], 3 * got + 2);
        end
        got++;
        n_chk++; if (prev_vld != 0) begin n_fail++; $display("FAIL b2b_pulse_width: rsp_valid high %0d cycles want 1", 2); end
      end
      prev_vld = int'(rsp_valid);
      if (req_ready && cyc < 9) rdy_win++;
      if (req_ready && issued < 3) begin
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3[issued]; req_addr = addr[issued]; req_wdata = 32'h0;
        acc[issued] = cyc;
        issued++;
      end else if (!req_ready && issued == 3) begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_chk++; if (got != 3) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want 3", got); end
    n_chk++; if (rdy_win != 3) begin n_fail++; $display("FAIL b2b_ready_pulses: got %0d want 3", rdy_win); end
    n_chk++; if (acc[1] != 3 || acc[2] != 6) begin n_fail++; $display("FAIL b2b_accept_spacing: got %0d,%0d want 3,6", acc[1], acc[2]); end
  endtask

  task automatic test_invariants();
    n_chk++; if (addr_viol != 0) begin n_fail++; $display("FAIL inv_addr_aligned: got %0d violations want 0", addr_viol); end
    n_chk++; if (idle_rd_viol != 0) begin n_fail++; $display("FAIL inv_rdata_idle_zero: got %0d violations want 0", idle_rd_viol); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
